// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the pipelined ripple-carry ALU:
//   DEFAULT_WIDTH  - default datapath width
//   ALU_*          - 4-bit operation codes {Ainvert, Bnegate, Op[1:0]}
//   OPSEL_*        - slice output select (Op[1:0])
//   alu_op_t       - field view of the 4-bit operation code
// -----------------------------------------------------------------------------
package alu_pkg;

    localparam int DEFAULT_WIDTH = 64;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] OPSEL_AND  = 2'b00;
    localparam logic [1:0] OPSEL_OR   = 2'b01;
    localparam logic [1:0] OPSEL_SUM  = 2'b10;
    localparam logic [1:0] OPSEL_LESS = 2'b11;

    typedef struct packed {
        logic       ainvert;
        logic       bnegate;
        logic [1:0] opsel;
    } alu_op_t;

endpackage

// File: rtl/alu_bit_slice.sv
// -----------------------------------------------------------------------------
// alu_bit_slice
// One bit of the ripple ALU: optional operand inversion, full adder and a
// 4-way output select. The MSB instance (IS_MSB=1) also produces Set and
// Overflow; ordinary slices tie those outputs to 0.
// Ports:
//   a, b       operand bits
//   less       value presented when opsel = LESS
//   ainvert    use ~a
//   bnegate    use ~b
//   cin        carry in
//   opsel      output select (AND / OR / SUM / LESS)
//   result     slice output
//   cout       carry out
//   set        MSB only: signed less-than of the subtraction
//   overflow   MSB only: signed overflow of the addition
// -----------------------------------------------------------------------------
module alu_bit_slice
    import alu_pkg::*;
#(
    parameter bit IS_MSB = 1'b0
) (
    input  logic       a,
    input  logic       b,
    input  logic       less,
    input  logic       ainvert,
    input  logic       bnegate,
    input  logic       cin,
    input  logic [1:0] opsel,
    output logic       result,
    output logic       cout,
    output logic       set,
    output logic       overflow
);

    logic w_a;
    logic w_b;
    logic w_sum;

    assign w_a   = a ^ ainvert;
    assign w_b   = b ^ bnegate;
    assign w_sum = w_a ^ w_b ^ cin;
    assign cout  = (w_a & w_b) | (w_a & cin) | (w_b & cin);

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case can leave it unassigned and infer a latch.
    always_comb begin
        result = 1'b0;
        case (opsel)
            OPSEL_AND:  result = w_a & w_b;
            OPSEL_OR:   result = w_a | w_b;
            OPSEL_SUM:  result = w_sum;
            OPSEL_LESS: result = less;
            default:    result = 1'b0;
        endcase
    end

    if (IS_MSB) begin : gen_msb_flags
        logic w_ovf;
        assign w_ovf    = cin ^ cout;
        // XOR with overflow restores the true sign when the subtraction wraps.
        assign set      = w_sum ^ w_ovf;
        assign overflow = w_ovf;
    end else begin : gen_no_flags
        assign set      = 1'b0;
        assign overflow = 1'b0;
    end

endmodule

// File: rtl/alu64_pipe.sv
// -----------------------------------------------------------------------------
// alu64_pipe
// Ripple-carry integer ALU (AND, OR, ADD, SUB, SLT, NOR) built from WIDTH
// bit slices, with registered outputs and a fixed 1-cycle latency.
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands and operation valid this cycle
//   a, b       two's complement operands
//   operation  {Ainvert, Bnegate, Op[1:0]}
//   out_valid  result registers hold a fresh result
//   result     registered ALU result
//   overflow   registered signed overflow (add/sub only)
//   zero       registered flag, 1 when result is all zeros
// -----------------------------------------------------------------------------
module alu64_pipe
    import alu_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       operation,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    alu_op_t          w_op;
    logic [WIDTH-1:0] w_result;
    logic             w_msb_set;
    logic             w_msb_ovf;
    logic             w_overflow;
    logic             w_zero;
    logic             w_unused_msb_cout;

    assign w_op = alu_op_t'(operation);

    for (genvar i = 0; i < WIDTH; i++) begin : gen_slice
        logic w_cin;
        logic w_cout;

        // Subtraction is a + ~b + 1: Bnegate doubles as the chain's carry-in.
        if (i == 0) begin : gen_cin_lsb
            assign w_cin = w_op.bnegate;
        end else begin : gen_cin_chain
            assign w_cin = gen_slice[i-1].w_cout;
        end

        if (i == WIDTH - 1) begin : gen_msb
            alu_bit_slice #(.IS_MSB(1'b1)) u_slice (
                .a        (a[i]),
                .b        (b[i]),
                .less     (1'b0),
                .ainvert  (w_op.ainvert),
                .bnegate  (w_op.bnegate),
                .cin      (w_cin),
                .opsel    (w_op.opsel),
                .result   (w_result[i]),
                .cout     (w_cout),
                .set      (w_msb_set),
                .overflow (w_msb_ovf)
            );
        end else begin : gen_lsb
            logic w_unused_set;
            logic w_unused_ovf;
            // Only bit 0 receives Set, which makes SLT produce {0..0, Set}.
            alu_bit_slice #(.IS_MSB(1'b0)) u_slice (
                .a        (a[i]),
                .b        (b[i]),
                .less     ((i == 0) ? w_msb_set : 1'b0),
                .ainvert  (w_op.ainvert),
                .bnegate  (w_op.bnegate),
                .cin      (w_cin),
                .opsel    (w_op.opsel),
                .result   (w_result[i]),
                .cout     (w_cout),
                .set      (w_unused_set),
                .overflow (w_unused_ovf)
            );
        end
    end

    // Carry out of the MSB has no architectural meaning (modulo arithmetic).
    assign w_unused_msb_cout = gen_slice[WIDTH-1].w_cout;

    assign w_overflow = (w_op.opsel == OPSEL_SUM) ? w_msb_ovf : 1'b0;
    assign w_zero     = (w_result == '0);

    logic [WIDTH-1:0] r_result;
    logic             r_overflow;
    logic             r_zero;
    logic             r_out_valid;

    // NOTE: state is written with non-blocking assignments so every register
    // samples pre-edge values; reset clears the outputs asynchronously, which
    // also discards whatever operation was in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_result    <= '0;
            r_overflow  <= 1'b0;
            r_zero      <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_result   <= w_result;
                r_overflow <= w_overflow;
                r_zero     <= w_zero;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign overflow  = r_overflow;
    assign zero      = r_zero;

endmodule

// File: tb/tb_alu64_pipe.sv
// -----------------------------------------------------------------------------
// tb_alu64_pipe
// Scoreboard bench for alu64_pipe: the driver pushes the expected response
// (with the cycle it must appear in) for every valid operation, and a monitor
// on the falling edge pops and compares whenever out_valid is high. Idle
// cycles are checked against the last delivered result (hold behaviour).
// -----------------------------------------------------------------------------
module tb_alu64_pipe;
    import alu_pkg::*;

    localparam int W  = 64;
    localparam int WX = W + 2;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic         in_valid  = 1'b0;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic [3:0]   operation = '0;
    logic         out_valid;
    logic [W-1:0] result;
    logic         overflow;
    logic         zero;

    alu64_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .operation (operation),
        .out_valid (out_valid),
        .result    (result),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int           cyc;
        logic [W-1:0] res;
        logic         ovf;
        logic         zero;
    } exp_t;

    exp_t exp_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    logic [W-1:0] hold_res  = '0;
    logic         hold_ovf  = 1'b0;
    logic         hold_zero = 1'b0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: operands are conditionally inverted, then the exact
    // signed sum is formed with two guard bits. Overflow means the exact sum
    // does not fit in W signed bits; Set is the sign of the exact sum.
    function automatic void model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                  input logic [3:0] mop,
                                  output logic [W-1:0] mres, output logic movf);
        logic [W-1:0]  ai;
        logic [W-1:0]  bi;
        logic [WX-1:0] exact;
        logic          add_ovf;
        logic          set;
        ai      = mop[3] ? ~ma : ma;
        bi      = mop[2] ? ~mb : mb;
        exact   = {{2{ai[W-1]}}, ai} + {{2{bi[W-1]}}, bi} + WX'(mop[2]);
        add_ovf = (exact[W] != exact[W-1]);
        set     = exact[WX-1];
        case (mop[1:0])
            2'b00:   mres = ai & bi;
            2'b01:   mres = ai | bi;
            2'b10:   mres = exact[W-1:0];
            default: mres = {{(W-1){1'b0}}, set};
        endcase
        movf = (mop[1:0] == 2'b10) && add_ovf;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(0, 5))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            4:       return W'($urandom_range(0, 15));
            default: return {$urandom(), $urandom()};
        endcase
    endfunction

    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb_op,
                         input logic [3:0] top,
                         input logic [W-1:0] eres, input logic eovf);
        @(posedge clk);
        #1;
        a         = ta;
        b         = tb_op;
        operation = top;
        in_valid  = 1'b1;
        exp_q.push_back('{cyc + 1, eres, eovf, (eres == '0)});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        a         = {$urandom(), $urandom()};
        b         = {$urandom(), $urandom()};
        operation = 4'($urandom_range(0, 15));
    endtask

    // Monitor: compares delivered results, checks hold on idle cycles and
    // flushes expectations when reset drops the in-flight operation.
    always @(negedge clk or negedge rst_n) begin
        exp_t e;
        if (!rst_n) begin
            exp_q.delete();
            hold_res  = '0;
            hold_ovf  = 1'b0;
            hold_zero = 1'b0;
        end else if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check($sformatf("unexpected_out_valid@%0d", cyc), W'(out_valid), '0);
            end else begin
                e = exp_q.pop_front();
                check($sformatf("latency@%0d", cyc), W'(cyc), W'(e.cyc));
                check($sformatf("result@%0d", cyc), result, e.res);
                check($sformatf("overflow@%0d", cyc), W'(overflow), W'(e.ovf));
                check($sformatf("zero@%0d", cyc), W'(zero), W'(e.zero));
                hold_res  = e.res;
                hold_ovf  = e.ovf;
                hold_zero = e.zero;
            end
        end else begin
            check($sformatf("idle_out_valid@%0d", cyc), W'(out_valid), '0);
            check($sformatf("hold_result@%0d", cyc), result, hold_res);
            check($sformatf("hold_overflow@%0d", cyc), W'(overflow), W'(hold_ovf));
            check($sformatf("hold_zero@%0d", cyc), W'(zero), W'(hold_zero));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [3:0]   rop;
        logic [W-1:0] mres;
        logic         movf;

        // Reset at time 1 (a real falling edge), check before any clock edge.
        #1 rst_n = 1'b0;
        #2;
        check("reset_result", result, '0);
        check("reset_overflow", W'(overflow), '0);
        check("reset_zero", W'(zero), '0);
        check("reset_out_valid", W'(out_valid), '0);
        #5 rst_n = 1'b1;

        // Directed vectors, issued back to back.
        issue(64'd123, 64'd4,   ALU_ADD, 64'd127, 1'b0);
        issue(64'd254, 64'd254, ALU_SUB, 64'd0,   1'b0);
        issue(64'd20,  64'd111, ALU_SUB, 64'hFFFF_FFFF_FFFF_FFA5, 1'b0);
        issue(64'd10,  64'd12,  ALU_AND, 64'd8,   1'b0);
        issue(64'd10,  64'd12,  ALU_OR,  64'd14,  1'b0);
        issue(64'd10,  64'd12,  ALU_NOR, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0);
        issue(64'd123, 64'd10242, ALU_SLT, 64'd1, 1'b0);
        issue(-64'sd5, 64'd12,  ALU_SLT, 64'd1,   1'b0);
        issue(64'd12,  -64'sd5, ALU_SLT, 64'd0,   1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, '1, ALU_SLT, 64'd0, 1'b0);
        issue(64'h8000_0000_0000_0000, 64'd1, ALU_SLT, 64'd1, 1'b0);
        issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, ALU_ADD, 64'h8000_0000_0000_0000, 1'b1);
        issue(64'h8000_0000_0000_0000, 64'd1, ALU_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
        issue(-64'sd5, 64'd12,  ALU_ADD, 64'd7,   1'b0);
        idle();
        idle();
        idle();

        // Mid-stream reset: the issued ADD must never appear.
        issue(64'd1, 64'd2, ALU_ADD, 64'd3, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("midreset_result", result, '0);
        check("midreset_overflow", W'(overflow), '0);
        check("midreset_zero", W'(zero), '0);
        check("midreset_out_valid", W'(out_valid), '0);
        @(posedge clk);
        #1;
        check("reset_edge_result", result, '0);
        check("reset_edge_out_valid", W'(out_valid), '0);
        in_valid = 1'b0;
        #2 rst_n = 1'b1;
        idle();
        idle();
        issue(64'd5, 64'd5, ALU_SUB, 64'd0, 1'b0);
        idle();
        idle();

        // Randomized traffic with occasional idle cycles.
        repeat (600) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
            end else begin
                ra = rand_operand();
                rb = rand_operand();
                if ($urandom_range(0, 1) == 0) begin
                    case ($urandom_range(0, 5))
                        0:       rop = ALU_AND;
                        1:       rop = ALU_OR;
                        2:       rop = ALU_ADD;
                        3:       rop = ALU_SUB;
                        4:       rop = ALU_SLT;
                        default: rop = ALU_NOR;
                    endcase
                end else begin
                    rop = 4'($urandom_range(0, 15));
                end
                model(ra, rb, rop, mres, movf);
                issue(ra, rb, rop, mres, movf);
            end
        end
        idle();
        idle();
        idle();

        check("queue_drained", W'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/alu64_pipe.md
Name: alu64_pipe

Overview:
- 64-bit integer ALU for the RISC-V datapath.
- Built as a ripple chain of 1-bit slices: 63 ordinary slices plus one MSB slice that produces Set and Overflow.
- Supports AND, OR, ADD, SUB, SLT and NOR, selected by the 4-bit Operation code from the ALU control unit.
- Outputs are registered, so the block sits between operand fetch and the EX/MEM stage with a fixed 1-cycle latency.

Parameters:
- WIDTH, 64, datapath width. Must be ≥2; bit WIDTH-1 is the MSB slice.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operands and operation valid this cycle
- a  in  WIDTH  operand A (two's complement)
- b  in  WIDTH  operand B (two's complement)
- operation  in  4  {Ainvert, Bnegate, Op[1:0]}
- out_valid  out  1  result registers hold a fresh result
- result  out  WIDTH  registered ALU result
- overflow  out  1  registered signed overflow flag
- zero  out  1  registered flag, 1 when result equals 0

Behaviour:
- Operation fields:
  - bit3 Ainvert: each slice uses ~a[i].
  - bit2 Bnegate: each slice uses ~b[i], and carry-in of slice 0 equals 1.
  - Op[1:0] selects the slice output: 00 AND, 01 OR, 10 sum, 11 Less.
- Named codes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0110 SUB
  - 0111 SLT
  - 1100 NOR
  - All 16 codes are legal and follow the field rules above, with no X generation.
- Slice: a' = a^Ainvert, b' = b^Bnegate; full adder sum = a'^b'^cin, cout = majority(a', b', cin).
- Ripple carry: cout of slice i feeds cin of slice i+1. Carry-out of the MSB is discarded.
- Less input: slice 0 takes Set from the MSB slice; all other slices take 0.
- MSB Overflow = cin[MSB] ^ cout[MSB].
- MSB Set = sum[MSB] ^ Overflow. This gives a correct signed less-than even when the subtraction overflows.
- SLT result = {63'b0, Set}.
- overflow flag:
  - Equals MSB Overflow only when Op[1:0]=10 (add or sub).
  - Forced to 0 for logic ops and SLT.
- zero flag: 1 iff the 64-bit combinational result is all zeros, for every operation.
- Timing:
  - Combinational path from a, b, operation to the next result.
  - Registers update on the rising clk edge when in_valid=1; they hold their value when in_valid=0.
  - out_valid <= in_valid every cycle. Latency is exactly 1 cycle, with full throughput of one operation per cycle and no backpressure.
- Reset (rst_n low, asynchronous):
  - result=0, overflow=0, zero=0, out_valid=0 immediately.
  - Release is synchronous to the next clk edge.
  - Reset asserted mid-stream drops the in-flight result.
- Wrap-around: ADD/SUB are modulo 2^64, e.g. 0x7FFF…F + 1 gives 0x8000…0 with overflow=1.

Decomposition:
- Shared package alu_pkg holds:
  - WIDTH default.
  - Operation code constants ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR.
  - Op-select constants OPSEL_AND/OR/SUM/LESS.
- One sub-module, alu_bit_slice:
  - Inputs: a, b, less, ainvert, bnegate, cin, opsel[1:0].
  - Outputs: result, cout, set, overflow.
  - Parameter IS_MSB enables the set/overflow logic.
- The top module instantiates the slice with a generate loop, then adds the zero detect, overflow gating and output registers.

Test Plan:
- ADD: a=123, b=4, op=0010, in_valid=1 → next cycle result=127, overflow=0, zero=0, out_valid=1.
- SUB/zero: a=254, b=254, op=0110 → result=0, zero=1. Then a=20, b=111, op=0110 → result=-91, zero=0, overflow=0.
- Logic: a=10, b=12. op=0000 → result=8. op=0001 → 14. op=1100 → ~14 (0xFFFF_FFFF_FFFF_FFF1).
- SLT:
  - a=123, b=10242 → result=1.
  - a=-5, b=12 → 1.
  - a=12, b=-5 → 0.
  - a=0x7FFF_FFFF_FFFF_FFFF, b=-1 → 0 (overflowing subtract; result stays correct), with overflow flag 0.
- Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, op=0010 → result=0x8000_0000_0000_0000, overflow=1. a=-5, b=12, op=0010 → 7, overflow=0.
- Reset/hold:
  - Assert rst_n=0 mid-stream → all outputs 0 immediately, without waiting for a clk edge.
  - After release, in_valid=0 → outputs hold their value, out_valid=0.
  - Back-to-back valid ops each appear exactly 1 cycle later.
